ps2_keyboard: RTL and testbench

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

---
 rtl/ps2_pkg.sv | 58 +++++
 rtl/ps2_code_map.sv | 112 +++++++++++
 rtl/ps2_keyboard.sv | 198 +++++++++++++++++++
 tb/tb_ps2_keyboard.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 keyboard receiver:
//               receive FSM state encoding, PS/2 set-2 prefix/modifier
//               bytes and Hack key codes for non-printable keys.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Receive frame FSM: start bit, 8 data bits, parity bit, stop bit
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // Set-2 prefix and modifier bytes
    localparam logic [7:0] SC_EXTEND = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // Hack key codes for non-printable keys
    localparam logic [15:0] KEY_NEWLINE   = 16'd128;
    localparam logic [15:0] KEY_BACKSPACE = 16'd129;
    localparam logic [15:0] KEY_LEFT      = 16'd130;
    localparam logic [15:0] KEY_UP        = 16'd131;
    localparam logic [15:0] KEY_RIGHT     = 16'd132;
    localparam logic [15:0] KEY_DOWN      = 16'd133;
    localparam logic [15:0] KEY_HOME      = 16'd134;
    localparam logic [15:0] KEY_END       = 16'd135;
    localparam logic [15:0] KEY_PGUP      = 16'd136;
    localparam logic [15:0] KEY_PGDN      = 16'd137;
    localparam logic [15:0] KEY_INSERT    = 16'd138;
    localparam logic [15:0] KEY_DELETE    = 16'd139;
    localparam logic [15:0] KEY_ESC       = 16'd140;
    localparam logic [15:0] KEY_F1        = 16'd141;
    localparam logic [15:0] KEY_F2        = 16'd142;
    localparam logic [15:0] KEY_F3        = 16'd143;
    localparam logic [15:0] KEY_F4        = 16'd144;
    localparam logic [15:0] KEY_F5        = 16'd145;
    localparam logic [15:0] KEY_F6        = 16'd146;
    localparam logic [15:0] KEY_F7        = 16'd147;
    localparam logic [15:0] KEY_F8        = 16'd148;
    localparam logic [15:0] KEY_F9        = 16'd149;
    localparam logic [15:0] KEY_F10       = 16'd150;
    localparam logic [15:0] KEY_F11       = 16'd151;
    localparam logic [15:0] KEY_F12       = 16'd152;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_code_map.sv
`default_nettype none
// ============================================================================
// Module      : ps2_code_map
// Description : Combinational translation of a set-2 make/break code byte
//               (plus extended-prefix and shift state) to a Hack key code.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_code_map
    import ps2_pkg::*;
(
    input  logic [7:0]  key_byte,
    input  logic        ext,
    input  logic        shift,
    output logic [15:0] code,
    output logic        mapped
);

    logic [7:0] letter;

    // Lowercase ASCII for letter keys, 0 when the byte is not a letter
    always_comb begin
        letter = 8'd0;
        case (key_byte)
            8'h1C: letter = 8'd97;   // a
            8'h32: letter = 8'd98;   // b
            8'h21: letter = 8'd99;   // c
            8'h23: letter = 8'd100;  // d
            8'h24: letter = 8'd101;  // e
            8'h2B: letter = 8'd102;  // f
            8'h34: letter = 8'd103;  // g
            8'h33: letter = 8'd104;  // h
            8'h43: letter = 8'd105;  // i
            8'h3B: letter = 8'd106;  // j
            8'h42: letter = 8'd107;  // k
            8'h4B: letter = 8'd108;  // l
            8'h3A: letter = 8'd109;  // m
            8'h31: letter = 8'd110;  // n
            8'h44: letter = 8'd111;  // o
            8'h4D: letter = 8'd112;  // p
            8'h15: letter = 8'd113;  // q
            8'h2D: letter = 8'd114;  // r
            8'h1B: letter = 8'd115;  // s
            8'h2C: letter = 8'd116;  // t
            8'h3C: letter = 8'd117;  // u
            8'h2A: letter = 8'd118;  // v
            8'h1D: letter = 8'd119;  // w
            8'h22: letter = 8'd120;  // x
            8'h35: letter = 8'd121;  // y
            8'h1A: letter = 8'd122;  // z
            default: letter = 8'd0;
        endcase
    end

    // Full translation: extended table when prefixed, else letters/digits/other keys
    always_comb begin
        code   = 16'd0;
        mapped = 1'b0;
        if (ext) begin
            case (key_byte)
                8'h6B:   code = KEY_LEFT;
                8'h75:   code = KEY_UP;
                8'h74:   code = KEY_RIGHT;
                8'h72:   code = KEY_DOWN;
                8'h6C:   code = KEY_HOME;
                8'h69:   code = KEY_END;
                8'h7D:   code = KEY_PGUP;
                8'h7A:   code = KEY_PGDN;
                8'h70:   code = KEY_INSERT;
                8'h71:   code = KEY_DELETE;
                default: code = 16'd0;
            endcase
            mapped = (code != 16'd0);
        end else if (letter != 8'd0) begin
            // Uppercase is 32 below lowercase in ASCII
            code   = {8'd0, (shift ? (letter - 8'd32) : letter)};
            mapped = 1'b1;
        end else begin
            case (key_byte)
                8'h45:   code = 16'd48;  // 0
                8'h16:   code = 16'd49;  // 1
                8'h1E:   code = 16'd50;  // 2
                8'h26:   code = 16'd51;  // 3
                8'h25:   code = 16'd52;  // 4
                8'h2E:   code = 16'd53;  // 5
                8'h36:   code = 16'd54;  // 6
                8'h3D:   code = 16'd55;  // 7
                8'h3E:   code = 16'd56;  // 8
                8'h46:   code = 16'd57;  // 9
                8'h29:   code = 16'd32;  // space
                8'h5A:   code = KEY_NEWLINE;
                8'h66:   code = KEY_BACKSPACE;
                8'h76:   code = KEY_ESC;
                8'h05:   code = KEY_F1;
                8'h06:   code = KEY_F2;
                8'h04:   code = KEY_F3;
                8'h0C:   code = KEY_F4;
                8'h03:   code = KEY_F5;
                8'h0B:   code = KEY_F6;
                8'h83:   code = KEY_F7;
                8'h0A:   code = KEY_F8;
                8'h01:   code = KEY_F9;
                8'h09:   code = KEY_F10;
                8'h78:   code = KEY_F11;
                8'h07:   code = KEY_F12;
                default: code = 16'd0;
            endcase
            mapped = (code != 16'd0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keyboard
// Description : PS/2 keyboard receiver. Synchronizes the device clock/data,
//               deframes 11-bit frames with odd parity, tracks E0/F0 prefixes
//               and shift state, and presents the Hack code of the key held.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] scancode,
    output logic        rx_strobe,
    output logic [7:0]  rx_byte,
    output logic        frame_error
);

    localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Synchronizers and falling-edge detect
    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;
    logic       ps2_clk_s;
    logic       ps2_data_s;
    logic       fall;

    // Frame receiver
    rx_state_t     state, state_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          parity_bit, parity_next;
    logic [TW-1:0] timeout_cnt, timeout_next;
    logic          accept;
    logic          bad_frame;
    logic          timeout_hit;

    // Key tracking
    logic        ext_pending;
    logic        break_pending;
    logic        shift_held;
    logic [15:0] map_code;
    logic        map_hit;

    // Two-flop synchronizers (idle-high bus) plus one flop of history for edge detect
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign ps2_clk_s  = clk_sync[1];
    assign ps2_data_s = data_sync[1];
    assign fall       = clk_prev & ~ps2_clk_s;

    // Receive FSM state and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'd0;
            parity_bit  <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            shift_reg   <= shift_next;
            parity_bit  <= parity_next;
            timeout_cnt <= timeout_next;
        end
    end

    // Next-state logic: frame deframing on ps2_clk falling edges, plus idle timeout
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        parity_next  = parity_bit;
        timeout_next = '0;
        accept       = 1'b0;
        bad_frame    = 1'b0;
        timeout_hit  = 1'b0;

        // Counter only runs mid-frame and restarts on every edge
        if ((state != ST_IDLE) && !fall) begin
            if (timeout_cnt == TIMEOUT_LAST) begin
                timeout_hit = 1'b1;
                state_next  = ST_IDLE;
            end else begin
                timeout_next = timeout_cnt + 1'b1;
            end
        end

        if (fall) begin
            case (state)
                ST_IDLE: begin
                    if (!ps2_data_s) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = 3'd0;
                    end else begin
                        bad_frame = 1'b1;
                    end
                end
                ST_DATA: begin
                    // LSB arrives first, so shift in from the top
                    shift_next   = {ps2_data_s, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_next = ps2_data_s;
                    state_next  = ST_STOP;
                end
                ST_STOP: begin
                    if (ps2_data_s && odd_parity_ok(shift_reg, parity_bit)) begin
                        accept = 1'b1;
                    end else begin
                        bad_frame = 1'b1;
                    end
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Registered byte outputs and one-cycle status pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_byte     <= 8'd0;
            rx_strobe   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_strobe   <= accept;
            frame_error <= bad_frame | timeout_hit;
            if (accept) begin
                rx_byte <= shift_reg;
            end
        end
    end

    ps2_code_map u_code_map (
        .key_byte (rx_byte),
        .ext      (ext_pending),
        .shift    (shift_held),
        .code     (map_code),
        .mapped   (map_hit)
    );

    // Prefix/shift tracking and held-key register, updated on each accepted byte
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ext_pending   <= 1'b0;
            break_pending <= 1'b0;
            shift_held    <= 1'b0;
            scancode      <= 16'd0;
        end else if (timeout_hit) begin
            ext_pending   <= 1'b0;
            break_pending <= 1'b0;
        end else if (rx_strobe) begin
            if (rx_byte == SC_EXTEND) begin
                ext_pending <= 1'b1;
            end else if (rx_byte == SC_BREAK) begin
                break_pending <= 1'b1;
            end else begin
                ext_pending   <= 1'b0;
                break_pending <= 1'b0;
                if ((rx_byte == SC_LSHIFT) || (rx_byte == SC_RSHIFT)) begin
                    shift_held <= ~break_pending;
                end else if (map_hit) begin
                    // Release clears only if it is the key currently shown
                    if (!break_pending) begin
                        scancode <= map_code;
                    end else if (map_code == scancode) begin
                        scancode <= 16'd0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_keyboard
// Description : Self-checking bench for ps2_keyboard: table of key vectors
//               plus directed sequences for latency, prefixes, errors,
//               timeout and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard;

    localparam int TIMEOUT = 400;
    localparam int HALF    = 10;
    localparam int GAP     = 12;
    localparam int NV      = 17;

    logic        clock;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] scancode;
    logic        rx_strobe;
    logic [7:0]  rx_byte;
    logic        frame_error;

    int n_checks = 0;
    int n_fail   = 0;

    int          strobe_cnt = 0;
    int          err_cnt    = 0;
    int          glitch_cnt = 0;
    logic        strobe_d   = 1'b0;
    logic [15:0] sc_at_strobe    = 16'd0;
    logic [15:0] sc_after_strobe = 16'd0;
    bit          watch_glitch    = 1'b0;

    typedef struct {
        bit          ext;
        logic [7:0]  code;
        bit          shift;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [NV];

    ps2_keyboard #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .scancode    (scancode),
        .rx_strobe   (rx_strobe),
        .rx_byte     (rx_byte),
        .frame_error (frame_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observe pulses and scancode around rx_strobe, on the inactive edge
    always @(negedge clock) begin
        if (rx_strobe)   strobe_cnt   <= strobe_cnt + 1;
        if (frame_error) err_cnt      <= err_cnt + 1;
        if (rx_strobe)   sc_at_strobe <= scancode;
        if (strobe_d)    sc_after_strobe <= scancode;
        strobe_d <= rx_strobe;
        if (watch_glitch && scancode != 16'd97) glitch_cnt <= glitch_cnt + 1;
    end

    // Hard stop in case something stalls
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cyc(HALF);
        ps2_clk = 1'b0;
        cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        cyc(GAP);
    endtask

    initial begin
        int e0;
        int s0;

        vecs[0]  = '{1'b0, 8'h1C, 1'b0, 16'd97};
        vecs[1]  = '{1'b0, 8'h1A, 1'b1, 16'd90};
        vecs[2]  = '{1'b0, 8'h4D, 1'b1, 16'd80};
        vecs[3]  = '{1'b0, 8'h45, 1'b0, 16'd48};
        vecs[4]  = '{1'b0, 8'h46, 1'b0, 16'd57};
        vecs[5]  = '{1'b0, 8'h29, 1'b0, 16'd32};
        vecs[6]  = '{1'b0, 8'h5A, 1'b0, 16'd128};
        vecs[7]  = '{1'b0, 8'h66, 1'b0, 16'd129};
        vecs[8]  = '{1'b0, 8'h76, 1'b0, 16'd140};
        vecs[9]  = '{1'b0, 8'h05, 1'b0, 16'd141};
        vecs[10] = '{1'b0, 8'h83, 1'b0, 16'd147};
        vecs[11] = '{1'b0, 8'h07, 1'b0, 16'd152};
        vecs[12] = '{1'b1, 8'h75, 1'b0, 16'd131};
        vecs[13] = '{1'b1, 8'h72, 1'b0, 16'd133};
        vecs[14] = '{1'b1, 8'h6C, 1'b0, 16'd134};
        vecs[15] = '{1'b1, 8'h71, 1'b0, 16'd139};
        vecs[16] = '{1'b0, 8'h0E, 1'b0, 16'd0};

        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        reset    = 1'b0;
        cyc(4);
        check("reset scancode", scancode, 0);
        check("reset rx_byte", rx_byte, 0);
        check("reset rx_strobe", rx_strobe, 0);
        check("reset frame_error", frame_error, 0);
        reset = 1'b1;
        cyc(4);

        // Make: scancode lags rx_strobe by exactly one cycle
        send_frame(8'h1C, 1'b0);
        check("A scancode at strobe", sc_at_strobe, 0);
        check("A scancode after strobe", sc_after_strobe, 97);
        check("A rx_byte", rx_byte, 8'h1C);
        send_frame(8'hF0, 1'b0);
        check("F0 keeps scancode", scancode, 97);
        send_frame(8'h1C, 1'b0);
        check("A release", scancode, 0);

        // Auto-repeat must never dip to 0
        send_frame(8'h1C, 1'b0);
        watch_glitch = 1'b1;
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        watch_glitch = 1'b0;
        check("repeat no glitch", glitch_cnt, 0);
        check("repeat scancode", scancode, 97);
        // Break of a different key leaves the held key
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1B, 1'b0);
        check("other break ignored", scancode, 97);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("repeat release", scancode, 0);

        // Shifted letter, then shift released
        send_frame(8'h12, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("shift A", scancode, 65);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("shift A release", scancode, 0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h12, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("shift cleared", scancode, 97);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);

        // Extended arrow press and release
        e0 = err_cnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h6B, 1'b0);
        check("E0 6B left", scancode, 130);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h6B, 1'b0);
        check("E0 F0 6B release", scancode, 0);
        check("ext no frame_error", err_cnt - e0, 0);

        // Table of key vectors: press, check, release, check
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].shift) send_frame(8'h12, 1'b0);
            if (vecs[i].ext)   send_frame(8'hE0, 1'b0);
            send_frame(vecs[i].code, 1'b0);
            check($sformatf("vec%0d make", i), scancode, vecs[i].exp);
            check($sformatf("vec%0d rx_byte", i), rx_byte, vecs[i].code);
            if (vecs[i].ext) send_frame(8'hE0, 1'b0);
            send_frame(8'hF0, 1'b0);
            send_frame(vecs[i].code, 1'b0);
            check($sformatf("vec%0d release", i), scancode, 0);
            if (vecs[i].shift) begin
                send_frame(8'hF0, 1'b0);
                send_frame(8'h12, 1'b0);
            end
        end
        check("vectors no frame_error", err_cnt - e0, 0);

        // Bad parity: one error, no strobe, state untouched
        send_frame(8'h0E, 1'b0);
        e0 = err_cnt;
        s0 = strobe_cnt;
        send_frame(8'h1C, 1'b1);
        check("parity err count", err_cnt - e0, 1);
        check("parity no strobe", strobe_cnt - s0, 0);
        check("parity scancode", scancode, 0);
        check("parity rx_byte kept", rx_byte, 8'h0E);

        // Start bit of 1 is rejected
        e0 = err_cnt;
        ps2_bit(1'b1);
        cyc(GAP);
        check("start bit err", err_cnt - e0, 1);

        // Timeout mid-frame also drops a pending E0 prefix
        send_frame(8'hE0, 1'b0);
        e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        cyc(TIMEOUT + 2);
        check("timeout err", err_cnt - e0, 1);
        send_frame(8'h29, 1'b0);
        check("after timeout space", scancode, 32);
        check("timeout single err", err_cnt - e0, 1);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b0);
        check("space release", scancode, 0);

        // Two keys, release first; then reset mid-frame
        send_frame(8'h1C, 1'b0);
        check("A then", scancode, 97);
        send_frame(8'h1B, 1'b0);
        check("S pressed", scancode, 115);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("S stays", scancode, 115);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        #3;
        reset = 1'b0;
        #1;
        check("reset mid scancode", scancode, 0);
        check("reset mid rx_byte", rx_byte, 0);
        cyc(3);
        reset = 1'b1;
        cyc(3);
        s0 = strobe_cnt;
        send_frame(8'h1C, 1'b0);
        check("resume strobe", strobe_cnt - s0, 1);
        check("resume scancode", scancode, 97);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
